// File: rtl/avg_pool_pkg.sv
// Shared types and geometry helpers for the sequential average-pooling controller.
package avg_pool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int f_ow(input int w, input int kw);
    return w / kw;
  endfunction

  function automatic int f_oh(input int h, input int kh);
    return h / kh;
  endfunction

  function automatic int f_win(input int kh, input int kw);
    return kh * kw;
  endfunction

  function automatic int f_accw(input int bw, input int win);
    return bw + $clog2(win);
  endfunction

  function automatic int f_nwin(input int c, input int oh, input int ow);
    return c * oh * ow;
  endfunction

  // Counter width that stays at least one bit for a modulus of 1.
  function automatic int f_cntw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avg_pool_ctrl_if.sv
// Start/status handshake plus input-buffer read port and output-buffer write port.
interface avg_pool_ctrl_if #(
  parameter int BITWIDTH  = 8,
  parameter int ADDRWIDTH = 12
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDRWIDTH-1:0] rd_addr;
  logic [BITWIDTH-1:0]  rd_data;
  logic                 wr_en;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [BITWIDTH-1:0]  wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/avg_pool_addr_gen.sv
// Nested window/pixel counters (kx fastest, then ky; ox, oy, c) and buffer address generation.
module avg_pool_addr_gen
  import avg_pool_pkg::*;
#(
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3,
  parameter int KWIDTH      = 2,
  parameter int KHEIGHT     = 2,
  parameter int ADDRWIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_adv_pix,
  input  logic                 i_adv_win,
  output logic [ADDRWIDTH-1:0] o_rd_addr_nxt,
  output logic [ADDRWIDTH-1:0] o_wr_addr,
  output logic                 o_last_pixel,
  output logic                 o_last_window
);
  localparam int OW  = f_ow(DATAWIDTH, KWIDTH);
  localparam int OH  = f_oh(DATAHEIGHT, KHEIGHT);
  localparam int KXW = f_cntw(KWIDTH);
  localparam int KYW = f_cntw(KHEIGHT);
  localparam int OXW = f_cntw(OW);
  localparam int OYW = f_cntw(OH);
  localparam int CW  = f_cntw(DATACHANNEL);

  logic [KXW-1:0] r_kx, w_kx;
  logic [KYW-1:0] r_ky, w_ky;
  logic [OXW-1:0] r_ox, w_ox;
  logic [OYW-1:0] r_oy, w_oy;
  logic [CW-1:0]  r_c,  w_c;

  // Counter next-state: clear has priority, pixel and window advances wrap independently
  always_comb begin
    w_kx = r_kx;
    w_ky = r_ky;
    w_ox = r_ox;
    w_oy = r_oy;
    w_c  = r_c;
    if (i_clr) begin
      w_kx = KXW'(0);
      w_ky = KYW'(0);
      w_ox = OXW'(0);
      w_oy = OYW'(0);
      w_c  = CW'(0);
    end else begin
      if (i_adv_pix) begin
        if (r_kx == KXW'(KWIDTH - 1)) begin
          w_kx = KXW'(0);
          w_ky = (r_ky == KYW'(KHEIGHT - 1)) ? KYW'(0) : r_ky + KYW'(1);
        end else begin
          w_kx = r_kx + KXW'(1);
        end
      end else begin
        w_kx = r_kx;
      end
      if (i_adv_win) begin
        if (r_ox == OXW'(OW - 1)) begin
          w_ox = OXW'(0);
          if (r_oy == OYW'(OH - 1)) begin
            w_oy = OYW'(0);
            w_c  = (r_c == CW'(DATACHANNEL - 1)) ? CW'(0) : r_c + CW'(1);
          end else begin
            w_oy = r_oy + OYW'(1);
          end
        end else begin
          w_ox = r_ox + OXW'(1);
        end
      end else begin
        w_ox = r_ox;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx <= KXW'(0);
      r_ky <= KYW'(0);
      r_ox <= OXW'(0);
      r_oy <= OYW'(0);
      r_c  <= CW'(0);
    end else begin
      r_kx <= w_kx;
      r_ky <= w_ky;
      r_ox <= w_ox;
      r_oy <= w_oy;
      r_c  <= w_c;
    end
  end

  // Read address is taken from the next counter values so the top can register it on issue.
  assign o_rd_addr_nxt = ADDRWIDTH'(w_c) * ADDRWIDTH'(DATAHEIGHT * DATAWIDTH)
                       + (ADDRWIDTH'(w_oy) * ADDRWIDTH'(KHEIGHT) + ADDRWIDTH'(w_ky)) * ADDRWIDTH'(DATAWIDTH)
                       + ADDRWIDTH'(w_ox) * ADDRWIDTH'(KWIDTH) + ADDRWIDTH'(w_kx);

  assign o_wr_addr = ADDRWIDTH'(r_c) * ADDRWIDTH'(OH * OW)
                   + ADDRWIDTH'(r_oy) * ADDRWIDTH'(OW) + ADDRWIDTH'(r_ox);

  assign o_last_pixel  = (r_kx == KXW'(KWIDTH - 1)) && (r_ky == KYW'(KHEIGHT - 1));
  assign o_last_window = (r_ox == OXW'(OW - 1)) && (r_oy == OYW'(OH - 1))
                      && (r_c == CW'(DATACHANNEL - 1));

endmodule

// File: rtl/avg_pool_ctrl.sv
// Sequential KHEIGHT x KWIDTH average pooling: one window at a time through a shared averager.
// Optional macro AVG_POOL_ROUND_EN selects round-half-up averaging instead of truncation.
module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3,
  parameter int KWIDTH      = 2,
  parameter int KHEIGHT     = 2,
  parameter int ADDRWIDTH   = 12
) (
  input logic             clk,
  input logic             rst,
  avg_pool_ctrl_if.master bus
);
  localparam int WIN  = f_win(KHEIGHT, KWIDTH);
  localparam int ACCW = f_accw(BITWIDTH, WIN);

  state_e               r_state, w_next_state;
  logic                 w_clr, w_adv_pix, w_adv_win;
  logic                 w_last_pixel, w_last_window, w_first_rd;
  logic [ADDRWIDTH-1:0] w_rd_addr_nxt, w_wr_addr;
  logic [ACCW-1:0]      r_acc, w_sum;
  logic [BITWIDTH-1:0]  w_avg;
  logic                 r_rd_vld, r_rd_en, r_wr_en, r_busy, r_done;
  logic [ADDRWIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [BITWIDTH-1:0]  r_wr_data;

  avg_pool_addr_gen #(
    .DATAWIDTH  (DATAWIDTH),
    .DATAHEIGHT (DATAHEIGHT),
    .DATACHANNEL(DATACHANNEL),
    .KWIDTH     (KWIDTH),
    .KHEIGHT    (KHEIGHT),
    .ADDRWIDTH  (ADDRWIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_adv_pix    (w_adv_pix),
    .i_adv_win    (w_adv_win),
    .o_rd_addr_nxt(w_rd_addr_nxt),
    .o_wr_addr    (w_wr_addr),
    .o_last_pixel (w_last_pixel),
    .o_last_window(w_last_window)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_adv_pix    = 1'b0;
    w_adv_win    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_READ;
          w_clr        = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        w_adv_pix    = 1'b1;
        w_next_state = w_last_pixel ? ST_DRAIN : ST_READ;
      end
      ST_DRAIN: w_next_state = ST_WRITE;
      ST_WRITE: begin
        w_adv_win    = 1'b1;
        w_next_state = w_last_window ? ST_DONE : ST_READ;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_first_rd = (w_next_state == ST_READ) && (r_state != ST_READ);
  assign w_sum      = r_acc + ACCW'(bus.rd_data);

`ifdef AVG_POOL_ROUND_EN
  localparam int ACCRW = ACCW + 1;
  logic [ACCRW-1:0] w_sum_rnd;
  assign w_sum_rnd = ACCRW'(w_sum) + ACCRW'(WIN / 2);
  assign w_avg     = BITWIDTH'(w_sum_rnd / ACCRW'(WIN));
`else
  assign w_avg     = BITWIDTH'(w_sum / ACCW'(WIN));
`endif

  // Accumulator: data returns one cycle after each read strobe, the last one lands in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= ACCW'(0);
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= r_rd_en;
      if (w_first_rd) begin
        r_acc <= ACCW'(0);
      end else if (r_rd_vld) begin
        r_acc <= w_sum;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  // Registered outputs, loaded from the upcoming state; addresses hold while strobes are low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= ADDRWIDTH'(0);
      r_wr_en   <= 1'b0;
      r_wr_addr <= ADDRWIDTH'(0);
      r_wr_data <= BITWIDTH'(0);
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en <= (w_next_state == ST_READ);
      r_wr_en <= (w_next_state == ST_WRITE);
      r_busy  <= (w_next_state == ST_READ) || (w_next_state == ST_DRAIN)
              || (w_next_state == ST_WRITE);
      r_done  <= (w_next_state == ST_DONE);
      if (w_next_state == ST_READ) begin
        r_rd_addr <= w_rd_addr_nxt;
      end else begin
        r_rd_addr <= r_rd_addr;
      end
      if (w_next_state == ST_WRITE) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= w_avg;
      end else begin
        r_wr_addr <= r_wr_addr;
        r_wr_data <= r_wr_data;
      end
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: doc/avg_pool_ctrl.md
Name: avg_pool_ctrl

Overview:
- Sequential scheduler that computes KHEIGHT x KWIDTH average pooling with one shared window averager, one window at a time.
- Reads the input feature map from a single-port buffer with 1-cycle read latency, accumulates the window, divides, and writes one result per window to an output buffer.
- Replaces the fully parallel pooling array where area matters. Sits between the conv-layer output buffer and the next layer's input buffer.

Parameters:
- BITWIDTH, 8, unsigned pixel width.
- DATAWIDTH, 28, input map width.
- DATAHEIGHT, 28, input map height.
- DATACHANNEL, 3, channel count.
- KWIDTH, 2, window width; must divide DATAWIDTH.
- KHEIGHT, 2, window height; must divide DATAHEIGHT.
- ADDRWIDTH, 12, buffer address width; must be at least clog2(DATAWIDTH*DATAHEIGHT*DATACHANNEL).

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Level; sampled only in IDLE.
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse after the last write.
- rd_en  out  1  Input buffer read strobe.
- rd_addr  out  ADDRWIDTH  Input address = c*H*W + y*W + x.
- rd_data  in  BITWIDTH  Valid the cycle after rd_en.
- wr_en  out  1  Output buffer write strobe.
- wr_addr  out  ADDRWIDTH  Output address = c*OH*OW + oy*OW + ox, with OH = H/KH and OW = W/KW.
- wr_data  out  BITWIDTH  Window average.

Behaviour:
- Reset (asynchronous): state IDLE, all counters 0, accumulator 0. busy, done, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: if start=1, go to READ and clear all counters. Otherwise stay.
- READ:
  - rd_en=1 for exactly WIN = KH*KW consecutive cycles.
  - Window pixel order is ky-major, then kx: (oy*KH+ky, ox*KW+kx).
  - After the WIN-th read, go to DRAIN.
- Accumulate: acc += rd_data in every cycle after an rd_en. acc is cleared when a window's first read is issued.
- DRAIN: one cycle; captures the last rd_data; then go to WRITE.
- WRITE:
  - wr_en=1 for one cycle; wr_data = acc / WIN (unsigned, truncating).
  - Advance counters in order ox, oy, c (ox fastest).
  - After the final window (c=C-1, oy=OH-1, ox=OW-1), go to DONE; otherwise go to READ.
- DONE: done=1 and busy=0 for one cycle; then go to IDLE.
- Window latency is WIN+2 cycles.
- Total time from start acceptance to done is C*OH*OW*(WIN+2)+1 cycles. With defaults this is 3529 cycles.
- Widths:
  - acc width = BITWIDTH + clog2(WIN); no overflow is possible.
  - Quotient is at most 2^BITWIDTH-1; wr_data is the low BITWIDTH bits.
- start while busy is ignored.
- start held high gives an automatic restart after DONE -> IDLE, with one idle cycle between runs.
- rst mid-run: outputs go to 0 immediately. No partial-window write occurs after reset asserts. The next start restarts at window 0.
- rd_addr and wr_addr are held at their last values when the corresponding strobe is low. Output is don't-care only after reset.

Optional Feature:
- Macro: AVG_POOL_ROUND_EN.
- Defined: wr_data = (acc + WIN/2) / WIN, i.e. round half up.
- Undefined: truncating division as above.
- Latency and interface are identical in both cases.

Decomposition:
- Package avg_pool_pkg contains:
  - the state enum;
  - functions deriving OW, OH, WIN, ACCW = BITWIDTH+clog2(WIN), and NWIN = C*OH*OW.
- Sub-module avg_pool_addr_gen:
  - nested counters kx, ky, ox, oy, c with advance/clear inputs;
  - rd_addr and wr_addr computation;
  - last_pixel and last_window flags.
- FSM, accumulator and divider stay in avg_pool_ctrl.

Test Plan:
- Reset: rst=1 mid-cycle -> busy, done, rd_en, wr_en, rd_addr, wr_addr and wr_data are all 0 without waiting for a clock edge.
- Default params, mem[a]=a mod 256, start pulse:
  - first-window rd_addr sequence is 0,1,28,29;
  - first write is wr_addr=0, wr_data=14 (15 with AVG_POOL_ROUND_EN);
  - second window reads 2,3,30,31.
- Channel crossing: window c=1,oy=0,ox=0 reads 784,785,812,813 and writes wr_addr=196.
- Full run with all pixels 255:
  - 588 writes, all wr_data=255;
  - last wr_addr=587;
  - done pulses exactly 3529 cycles after start is sampled, for one cycle.
- start toggled during busy -> no effect on the address sequence. start held high -> second run begins with rd_en one cycle after the IDLE cycle that follows done.
- rst asserted during window 100 READ, then released, then start -> no write with wr_addr>=100 before restart; first write is wr_addr=0.
